// File: rtl/regwb.sv
// -----------------------------------------------------------------------------
// regwb -- dual-issue register write-back queue
//
// Collects up to two results per cycle from a dual-issue pipeline (slot A is
// the older instruction, slot B the younger) and drains them in program order
// onto two register-file write ports.
//
// Ports
//   clk                      rising-edge clock for all state
//   reset_n                  asynchronous active-low reset
//   inA_valid/inA_reg/inA_data  older result: valid, destination, value
//   inB_valid/inB_reg/inB_data  younger result: valid, destination, value
//   in_ready                 queue has room for two results this cycle
//   rf_stall                 register-file write ports unavailable this cycle
//   regwriteA/wrregA/wrdataA  write port A (queue head)
//   regwriteB/wrregB/wrdataB  write port B (queue head + 1)
//   pend_mask                bit r set while any queued entry targets register r
//   count                    number of queued entries
// -----------------------------------------------------------------------------
module regwb #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,

    input  logic                       inA_valid,
    input  logic [4:0]                 inA_reg,
    input  logic [31:0]                inA_data,
    input  logic                       inB_valid,
    input  logic [4:0]                 inB_reg,
    input  logic [31:0]                inB_data,
    output logic                       in_ready,

    input  logic                       rf_stall,
    output logic                       regwriteA,
    output logic [4:0]                 wrregA,
    output logic [31:0]                wrdataA,
    output logic                       regwriteB,
    output logic [4:0]                 wrregB,
    output logic [31:0]                wrdataB,

    output logic [31:0]                pend_mask,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Queue storage and circular pointers.
    logic [4:0]    q_reg  [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;

    // Per-cycle decisions.
    logic          enq_a;
    logic          enq_b;
    logic [AW-1:0] wr_idx_b;
    logic [1:0]    n_enq;
    logic [1:0]    n_deq;
    logic [AW-1:0] head_p1;
    logic          present_a;
    logic          present_b;
    logic          same_dest;

    // -------------------------------------------------------------------------
    // Enqueue side. Readiness looks only at the registered count, so a drain
    // in the same cycle never creates room for an incoming pair.
    // -------------------------------------------------------------------------
    assign in_ready = (CW'(DEPTH) - count_q) >= CW'(2);

    // Register 0 is hardwired, so results targeting it are dropped here.
    assign enq_a = in_ready && inA_valid && (inA_reg != 5'd0);
    assign enq_b = in_ready && inB_valid && (inB_reg != 5'd0);

    // B lands directly behind A when both are taken, otherwise at the tail.
    assign wr_idx_b = enq_a ? (tail_q + AW'(1)) : tail_q;
    assign n_enq    = {1'b0, enq_a} + {1'b0, enq_b};

    // -------------------------------------------------------------------------
    // Drain side. Head goes to port A, head+1 to port B; whatever is presented
    // while rf_stall is low retires on the edge.
    // -------------------------------------------------------------------------
    assign head_p1   = head_q + AW'(1);
    assign present_a = (count_q >= CW'(1)) && !rf_stall;
    assign present_b = (count_q >= CW'(2)) && !rf_stall;
    assign n_deq     = {1'b0, present_a} + {1'b0, present_b};

    // When both presented entries target the same register the older value is
    // dead; only port B writes, but both entries still retire.
    assign same_dest = present_b && (q_reg[head_q] == q_reg[head_p1]);

    always_comb begin
        // NOTE: every output of a combinational block is assigned a default
        // first, so no path leaves it unassigned and no latch is inferred.
        regwriteA = 1'b0;
        wrregA    = 5'd0;
        wrdataA   = 32'd0;
        regwriteB = 1'b0;
        wrregB    = 5'd0;
        wrdataB   = 32'd0;

        if (present_a && !same_dest) begin
            regwriteA = 1'b1;
            wrregA    = q_reg[head_q];
            wrdataA   = q_data[head_q];
        end
        if (present_b) begin
            regwriteB = 1'b1;
            wrregB    = q_reg[head_p1];
            wrdataB   = q_data[head_p1];
        end
    end

    // -------------------------------------------------------------------------
    // Pending-register mask: one-hot of every live entry, walked from head.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [AW-1:0] idx;
        pend_mask = 32'd0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                idx = head_q + AW'(i);
                pend_mask[q_reg[idx]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    assign count = count_q;

    // -------------------------------------------------------------------------
    // Control state: pointers and occupancy. Reset empties the queue at once,
    // which also silences both write ports since they decode from count.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            head_q  <= head_q + AW'(n_deq);
            tail_q  <= tail_q + AW'(n_enq);
            count_q <= count_q + CW'(n_enq) - CW'(n_deq);
        end
    end

    // NOTE: the entry storage has no reset; an entry is only ever read while
    // count marks it live, so clearing it would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (enq_a) begin
            q_reg[tail_q]  <= inA_reg;
            q_data[tail_q] <= inA_data;
        end
        if (enq_b) begin
            q_reg[wr_idx_b]  <= inB_reg;
            q_data[wr_idx_b] <= inB_data;
        end
    end

endmodule

// File: tb/tb_regwb.sv
// -----------------------------------------------------------------------------
// tb_regwb -- self-checking bench for regwb (DEPTH = 4)
//
// A queue of {reg, data} results models the write-back buffer. Each cycle the
// bench drives inputs, compares every DUT output with what the queue says
// should be presented, then applies the clock edge to both.
// -----------------------------------------------------------------------------
module tb_regwb;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        reset_n;
    logic        inA_valid;
    logic [4:0]  inA_reg;
    logic [31:0] inA_data;
    logic        inB_valid;
    logic [4:0]  inB_reg;
    logic [31:0] inB_data;
    logic        in_ready;
    logic        rf_stall;
    logic        regwriteA;
    logic [4:0]  wrregA;
    logic [31:0] wrdataA;
    logic        regwriteB;
    logic [4:0]  wrregB;
    logic [31:0] wrdataB;
    logic [31:0] pend_mask;
    logic [$clog2(DEPTH):0] count;

    int   checks;
    int   failures;
    int   max_cnt;
    ent_t model_q[$];

    regwb #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .inA_valid (inA_valid),
        .inA_reg   (inA_reg),
        .inA_data  (inA_data),
        .inB_valid (inB_valid),
        .inB_reg   (inB_reg),
        .inB_data  (inB_data),
        .in_ready  (in_ready),
        .rf_stall  (rf_stall),
        .regwriteA (regwriteA),
        .wrregA    (wrregA),
        .wrdataA   (wrdataA),
        .regwriteB (regwriteB),
        .wrregB    (wrregB),
        .wrdataB   (wrdataB),
        .pend_mask (pend_mask),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: entered at posedge+1, drives inputs, compares outputs against
    // the queue model, takes the edge and leaves at posedge+1 again.
    task automatic drive_cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic bv, input logic [4:0] br, input logic [31:0] bd,
                               input logic st, input string tag);
        int          n;
        int          ndeq;
        logic        e_rdy, e_wa, e_wb;
        logic [4:0]  e_ra, e_rb;
        logic [31:0] e_da, e_db, e_mask;
        inA_valid = av; inA_reg = ar; inA_data = ad;
        inB_valid = bv; inB_reg = br; inB_data = bd;
        rf_stall  = st;
        #1;
        n      = model_q.size();
        e_rdy  = (DEPTH - n) >= 2;
        e_mask = 32'd0;
        foreach (model_q[i]) e_mask = e_mask | (32'd1 << model_q[i].r);
        e_wa = (n >= 1) && !st;
        e_wb = (n >= 2) && !st;
        if (e_wa && e_wb && model_q[0].r == model_q[1].r) e_wa = 1'b0;
        e_ra = e_wa ? model_q[0].r : 5'd0;
        e_da = e_wa ? model_q[0].d : 32'd0;
        e_rb = e_wb ? model_q[1].r : 5'd0;
        e_db = e_wb ? model_q[1].d : 32'd0;
        if (int'(count) > max_cnt) max_cnt = int'(count);

        checks++;
        if (int'(count) !== n || in_ready !== e_rdy || pend_mask !== e_mask) begin
            failures++;
            $display("FAIL %s status: count=%0d in_ready=%b pend_mask=%h, expected count=%0d in_ready=%b pend_mask=%h",
                     tag, count, in_ready, pend_mask, n, e_rdy, e_mask);
        end
        checks++;
        if (regwriteA !== e_wa || wrregA !== e_ra || wrdataA !== e_da) begin
            failures++;
            $display("FAIL %s portA: we=%b reg=%0d data=%h, expected we=%b reg=%0d data=%h",
                     tag, regwriteA, wrregA, wrdataA, e_wa, e_ra, e_da);
        end
        checks++;
        if (regwriteB !== e_wb || wrregB !== e_rb || wrdataB !== e_db) begin
            failures++;
            $display("FAIL %s portB: we=%b reg=%0d data=%h, expected we=%b reg=%0d data=%h",
                     tag, regwriteB, wrregB, wrdataB, e_wb, e_rb, e_db);
        end

        @(posedge clk);
        ndeq = st ? 0 : ((n >= 2) ? 2 : n);
        repeat (ndeq) void'(model_q.pop_front());
        if (e_rdy) begin
            if (av && ar != 5'd0) model_q.push_back('{r: ar, d: ad});
            if (bv && br != 5'd0) model_q.push_back('{r: br, d: bd});
        end
        #1;
    endtask

    task automatic idle_cycle(input logic st, input string tag);
        drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, st, tag);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        inA_valid = 1'b0; inA_reg = 5'd0; inA_data = 32'd0;
        inB_valid = 1'b0; inB_reg = 5'd0; inB_data = 32'd0;
        rf_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (count !== 3'd0 || in_ready !== 1'b1 || pend_mask !== 32'd0 ||
            regwriteA !== 1'b0 || regwriteB !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: count=%0d in_ready=%b pend=%h weA=%b weB=%b, expected 0/1/0/0/0",
                     count, in_ready, pend_mask, regwriteA, regwriteB);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle(1'b0, "reset_idle");
    endtask

    task automatic test_pair();
        drive_cycle(1'b1, 5'd8, 32'h11, 1'b1, 5'd9, 32'h22, 1'b0, "pair_enq");
        inA_valid = 1'b0; inB_valid = 1'b0;
        #1;
        checks++;
        if (regwriteA !== 1'b1 || wrregA !== 5'd8 || wrdataA !== 32'h11 ||
            regwriteB !== 1'b1 || wrregB !== 5'd9 || wrdataB !== 32'h22 || count !== 3'd2) begin
            failures++;
            $display("FAIL pair_lit: A=%b/%0d/%h B=%b/%0d/%h count=%0d, expected A=1/8/11 B=1/9/22 count=2",
                     regwriteA, wrregA, wrdataA, regwriteB, wrregB, wrdataB, count);
        end
        idle_cycle(1'b0, "pair_drain");
        #1;
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("FAIL pair_empty: count=%0d, expected 0", count);
        end
    endtask

    task automatic test_same_reg();
        drive_cycle(1'b1, 5'd8, 32'hAA, 1'b1, 5'd8, 32'hBB, 1'b0, "same_enq");
        inA_valid = 1'b0; inB_valid = 1'b0;
        #1;
        checks++;
        if (regwriteA !== 1'b0 || regwriteB !== 1'b1 || wrregB !== 5'd8 ||
            wrdataB !== 32'hBB || pend_mask !== 32'h100) begin
            failures++;
            $display("FAIL same_lit: weA=%b weB=%b regB=%0d dataB=%h pend=%h, expected 0/1/8/bb/00000100",
                     regwriteA, regwriteB, wrregB, wrdataB, pend_mask);
        end
        idle_cycle(1'b0, "same_drain");
        #1;
        checks++;
        if (count !== 3'd0 || pend_mask !== 32'd0) begin
            failures++;
            $display("FAIL same_retire: count=%0d pend=%h, expected 0/0", count, pend_mask);
        end
    endtask

    task automatic test_stall_full();
        drive_cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1, "full_p1");
        drive_cycle(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hB4, 1'b1, "full_p2");
        drive_cycle(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hB6, 1'b1, "full_p3");
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0 || pend_mask !== 32'h1E) begin
            failures++;
            $display("FAIL full_lit: count=%0d in_ready=%b pend=%h, expected 4/0/0000001e",
                     count, in_ready, pend_mask);
        end
        inA_valid = 1'b0; inB_valid = 1'b0; rf_stall = 1'b0;
        #1;
        checks++;
        if (wrregA !== 5'd1 || wrdataA !== 32'hA1 || wrregB !== 5'd2 || wrdataB !== 32'hB2) begin
            failures++;
            $display("FAIL full_drain1: A=%0d/%h B=%0d/%h, expected 1/a1 2/b2",
                     wrregA, wrdataA, wrregB, wrdataB);
        end
        idle_cycle(1'b0, "full_d1");
        #1;
        checks++;
        if (wrregA !== 5'd3 || wrdataA !== 32'hA3 || wrregB !== 5'd4 || wrdataB !== 32'hB4) begin
            failures++;
            $display("FAIL full_drain2: A=%0d/%h B=%0d/%h, expected 3/a3 4/b4",
                     wrregA, wrdataA, wrregB, wrdataB);
        end
        idle_cycle(1'b0, "full_d2");
        idle_cycle(1'b0, "full_d3");
    endtask

    task automatic test_reg0();
        drive_cycle(1'b1, 5'd0, 32'h5, 1'b1, 5'd3, 32'h7, 1'b0, "reg0_enq");
        inA_valid = 1'b0; inB_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd1 || pend_mask !== 32'h8 || regwriteA !== 1'b1 ||
            wrregA !== 5'd3 || wrdataA !== 32'h7 || regwriteB !== 1'b0) begin
            failures++;
            $display("FAIL reg0_lit: count=%0d pend=%h A=%b/%0d/%h weB=%b, expected 1/00000008/1/3/7/0",
                     count, pend_mask, regwriteA, wrregA, wrdataA, regwriteB);
        end
        idle_cycle(1'b0, "reg0_drain");
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h101, 1'b1, "ar_f1");
        drive_cycle(1'b1, 5'd12, 32'h102, 1'b0, 5'd0, 32'd0, 1'b1, "ar_f2");
        inA_valid = 1'b0; inB_valid = 1'b0; rf_stall = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || regwriteA !== 1'b0 || regwriteB !== 1'b0 ||
            pend_mask !== 32'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: count=%0d weA=%b weB=%b pend=%h rdy=%b, expected 0/0/0/0/1",
                     count, regwriteA, regwriteB, pend_mask, in_ready);
        end
        model_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) idle_cycle(1'b0, "ar_after");
    endtask

    task automatic test_back_to_back();
        logic [4:0] ra;
        max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            ra = 5'(1 + (2 * i) % 30);
            drive_cycle(1'b1, ra, $urandom, 1'b1, ra + 5'd1, $urandom, 1'b0, "b2b");
        end
        repeat (2) idle_cycle(1'b0, "b2b_drain");
        checks++;
        if (max_cnt > 2) begin
            failures++;
            $display("FAIL b2b_maxcount: max count=%0d, expected <= 2", max_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                        ($urandom_range(0, 9) < 3), "random");
        end
        repeat (3) idle_cycle(1'b0, "random_drain");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        max_cnt  = 0;
        test_reset();
        test_pair();
        test_same_reg();
        test_stall_full();
        test_reg0();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regwb.md
REGWB -- requirements
Module: regwb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result-queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port inA_valid  input  1  older issue slot result valid this cycle.
REQ-005 SHALL have ports inA_reg / inA_data  input  5 / 32  slot A destination register and value.
REQ-006 SHALL have port inB_valid  input  1  younger issue slot result valid this cycle.
REQ-007 SHALL have ports inB_reg / inB_data  input  5 / 32  slot B destination register and value.
REQ-008 SHALL have port in_ready  output  1  queue can accept two results this cycle.
REQ-009 SHALL have port rf_stall  input  1  register file write ports unavailable this cycle.
REQ-010 SHALL have ports regwriteA / wrregA / wrdataA  output  1 / 5 / 32  register-file write port A.
REQ-011 SHALL have ports regwriteB / wrregB / wrdataB  output  1 / 5 / 32  register-file write port B.
REQ-012 SHALL have port pend_mask  output  32  bit r set while any queued entry targets register r.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  queued entries.

Function
REQ-014 SHALL hold results in a circular FIFO of DEPTH entries {reg, data}, program order preserved.
REQ-015 SHALL drive in_ready = 1 when DEPTH - count >= 2, from registered count only (no same-cycle drain credit).
REQ-016 SHALL enqueue on the clock edge when in_ready=1: A (if valid) before B (if valid); both valid -> 2 entries, one valid -> 1 entry.
REQ-017 SHALL discard, not enqueue, any valid result with reg = 0.
REQ-018 SHALL ignore valid inputs while in_ready=0 (protocol violation; no state change from those inputs).
REQ-019 SHALL present the head entry on write port A and head+1 on write port B, combinationally from queue state.
REQ-020 SHALL assert regwriteA when count>=1 and rf_stall=0; regwriteB when count>=2 and rf_stall=0.
REQ-021 SHALL, when both presented entries target the same register, deassert regwriteA (younger B wins) yet still retire both entries.
REQ-022 SHALL retire on the clock edge exactly the entries presented with rf_stall=0 (0, 1 or 2), including the suppressed one of REQ-021.
REQ-023 SHALL update count = count + enq - deq in one edge; simultaneous enqueue and dequeue allowed; pointers wrap modulo DEPTH.
REQ-024 SHALL compute pend_mask as OR of one-hot(reg) over all valid queue entries; bit 0 always 0.
REQ-025 SHALL not bypass: a result enqueued at edge N is first presented on a write port after edge N (latency 1 cycle min).
REQ-026 SHALL drive wrreg*/wrdata* to 0 when the corresponding regwrite is 0.

Reset
REQ-027 SHALL, on reset_n=0, immediately clear pointers and count to 0, making regwriteA=regwriteB=0, pend_mask=0, in_ready=1.
REQ-028 SHALL discard queue contents on reset mid-operation; no write pulse after reset_n rises until new enqueue.
REQ-029 SHALL not require data storage to be reset.

Verification
REQ-030 A=($8,0x11), B=($9,0x22) with rf_stall=0 -> next cycle regwriteA=1 $8=0x11, regwriteB=1 $9=0x22, count 2 -> 0 after edge.
REQ-031 A=($8,0xAA), B=($8,0xBB) -> next cycle regwriteA=0, regwriteB=1 wrregB=8 wrdataB=0xBB; both retired, pend_mask[8] clears.
REQ-032 rf_stall=1, enqueue pairs for 2 cycles (DEPTH=4) -> count=4, in_ready=0; third pair ignored; release stall -> 2 pairs drain in order over 2 cycles.
REQ-033 A=($0,0x5), B=($3,0x7) -> count=1, pend_mask=0x8, only port A writes $3=0x7 next cycle.
REQ-034 Fill 3 entries with stall, assert reset_n=0 asynchronously mid-cycle -> count=0, regwrite*=0 at once; no writes after release.
REQ-035 Continuous pairs for 10 cycles with rf_stall=0 -> wrap-around correct, writes in program order, count never exceeds 2.
